// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: multi-cycle 16-bit shift/rotate sequencer.
// One logarithmic stage (1, 2, 4, 8 positions) is applied per cycle, gated by
// the matching amount bit, so every operation takes four RUN cycles.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready and out_valid are decoded from the registered state
// only, so neither depends combinationally on in_valid or out_ready. Once
// out_valid is high it stays high and out_data stays stable until out_ready.
module shift_seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic [3:0]  in_amt,
    input  logic [1:0]  in_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    logic [1:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] data_q, data_d;
    logic [3:0]  amt_q, amt_d;
    logic [1:0]  op_q, op_d;

    logic [4:0]  stage_sh;
    logic [4:0]  stage_wrap;
    logic [15:0] stage_res;

    // Result of the current stage: shift distance 2^cnt, applied only when
    // the matching amount bit is set.
    always_comb begin
        stage_sh   = 5'd1 << cnt_q;
        stage_wrap = 5'd16 - stage_sh;
        stage_res  = data_q;
        if (amt_q[cnt_q]) begin
            case (op_q)
                OP_ROL:  stage_res = (data_q << stage_sh) | (data_q >> stage_wrap);
                OP_SLL:  stage_res = data_q << stage_sh;
                OP_ROR:  stage_res = (data_q >> stage_sh) | (data_q << stage_wrap);
                OP_SRL:  stage_res = data_q >> stage_sh;
                default: stage_res = data_q;
            endcase
        end
    end

    // Next-state and datapath control for IDLE -> RUN x4 -> DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        amt_d   = amt_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    amt_d   = in_amt;
                    op_d    = in_op;
                    cnt_d   = 2'd0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                data_d = stage_res;
                cnt_d  = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset wins over any handshake and discards a result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            data_q  <= 16'h0000;
            amt_q   <= 4'd0;
            op_q    <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            op_q    <= op_d;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
        out_data  = data_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Testbench for shift_seq_ctrl: scoreboard of expected results, timing checks
// on handshakes, backpressure, mid-operation reset and back-to-back traffic.
module tb_shift_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_amt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;
    logic [1:0]  dbg_state;

    logic [15:0] exp_q[$];
    int          total;
    int          bad;
    int          cyc;
    int          acc_cyc;

    shift_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: n single-position steps.
    function automatic logic [15:0] model(input logic [15:0] d, input logic [3:0] a,
                                          input logic [1:0] o);
        logic [15:0] r;
        r = d;
        for (int i = 0; i < int'(a); i++) begin
            case (o)
                2'b00:   r = {r[14:0], r[15]};
                2'b01:   r = {r[14:0], 1'b0};
                2'b10:   r = {r[0], r[15:1]};
                default: r = {1'b0, r[15:1]};
            endcase
        end
        return r;
    endfunction

    // Scoreboard: compare every completed output transfer.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", {16'h0, out_data}, 32'hdead);
            end else begin
                check("out_data", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    // Drive a request; returns one tick after the accepting edge.
    task automatic send(input logic [15:0] d, input logic [3:0] a, input logic [1:0] o,
                        input logic [15:0] exp);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_op    = o;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'd0, 32'd1);
        end else begin
            acc_cyc = cyc;
            exp_q.push_back(exp);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    logic [15:0] sweep_exp [4][3];
    logic [3:0]  sweep_amt [3];
    logic [15:0] held;
    int          prev_acc;
    int          n;

    initial begin
        sweep_amt = '{4'd0, 4'd4, 4'd8};
        sweep_exp = '{'{16'h1234, 16'h2341, 16'h3412},
                      '{16'h1234, 16'h2340, 16'h3400},
                      '{16'h1234, 16'h4123, 16'h3412},
                      '{16'h1234, 16'h0123, 16'h0012}};
        total = 0; bad = 0; cyc = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_op = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_state", dbg_state, 2'd0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 16'h0000);
        check("rst_busy", busy, 1'b0);
        @(posedge clk);
        #1;

        // First operation latency: ROL 0x8001 by 1
        send(16'h8001, 4'd1, 2'b00, 16'h0003);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check("lat_in_ready", in_ready, 1'b0);
            check("lat_busy", busy, 1'b1);
            check("lat_out_valid", out_valid, (k == 5) ? 1'b1 : 1'b0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("lat_idle_ready", in_ready, 1'b1);
        check("lat_idle_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;

        // Sweep of all ops at amounts 0, 4, 8 on 0x1234
        for (int o = 0; o < 4; o++) begin
            for (int j = 0; j < 3; j++) begin
                send(16'h1234, sweep_amt[j], 2'(o), sweep_exp[o][j]);
            end
        end
        drain();

        // Extremes
        send(16'h00FF, 4'd12, 2'b01, 16'hF000);
        send(16'h0001, 4'd15, 2'b10, 16'h0002);
        send(16'h8000, 4'd15, 2'b11, 16'h0001);
        send(16'hFFFF, 4'd15, 2'b00, 16'hFFFF);
        drain();

        // Backpressure
        out_ready = 1'b0;
        send(16'hA5C3, 4'd3, 2'b10, model(16'hA5C3, 4'd3, 2'b10));
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_rise", out_valid, 1'b1);
        held = out_data;
        if (exp_q.size() != 0) check("bp_data_val", out_data, exp_q[0]);
        for (int k = 0; k < 3; k++) begin
            if (k == 1) in_valid = 1'b0;
            check("bp_valid_hold", out_valid, 1'b1);
            check("bp_data_hold", out_data, held);
            check("bp_in_ready", in_ready, 1'b0);
            @(posedge clk);
            #1;
            if (k == 0) begin
                in_valid = 1'b1;
                in_data  = 16'h0F0F;
                in_amt   = 4'd5;
                in_op    = 2'b00;
            end
            @(negedge clk);
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        check("bp_release_valid", out_valid, 1'b1);
        check("bp_release_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_idle_ready", in_ready, 1'b1);
        check("bp_idle_valid", out_valid, 1'b0);
        exp_q.push_back(model(16'h0F0F, 4'd5, 2'b00));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_second_busy", busy, 1'b1);
        drain();

        // Reset in the second RUN cycle
        send(16'h1357, 4'd9, 2'b01, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_state", dbg_state, 2'd0);
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_out_data", out_data, 16'h0000);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("abort_no_out", out_valid, 1'b0);
        end
        @(posedge clk);
        #1;

        // Back-to-back with random operands
        out_ready = 1'b1;
        prev_acc = -1;
        for (int k = 0; k < 8; k++) begin
            logic [15:0] d;
            logic [3:0]  a;
            logic [1:0]  o;
            d = 16'($urandom_range(0, 65535));
            a = 4'($urandom_range(0, 15));
            o = 2'($urandom_range(0, 3));
            send(d, a, o, model(d, a, o));
            if (prev_acc >= 0) check("b2b_interval", acc_cyc - prev_acc, 6);
            prev_acc = acc_cyc;
        end
        drain();

        repeat (3) @(posedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Multi-cycle shift/rotate sequencer for the execute stage. It accepts one 16-bit operand, a 4-bit shift amount and an op code over a valid/ready handshake. It then applies one logarithmic stage per cycle (1, 2, 4, 8 bit positions), gated by the matching amount bit, and returns the result over a second valid/ready handshake. The pipeline uses it for ROL/SLL/ROR/SRL when the single-cycle shifter is not instantiated or is claimed by another unit.

## Interface
- Parameters: none. Datapath is fixed at 16 bits, amount at 4 bits, op at 2 bits.
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request
- in_data  in  16  operand
- in_amt  in  4  shift amount, 0–15
- in_op  in  2  op code: 00 ROL, 01 SLL, 10 ROR, 11 SRL
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_data  out  16  result
- busy  out  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE. Stage counter `cnt` is 2 bits. Registers `data_r[15:0]`, `amt_r[3:0]`, `op_r[1:0]`.
- IDLE:
  - in_ready=1.
  - On in_valid=1, capture in_data/in_amt/in_op, set cnt=0 and go to RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle applies stage k=cnt with s=2^k:
  - If amt_r[k]=0, data_r is unchanged.
  - ROL: data_r <= {data_r[15-s:0], data_r[15:16-s]}
  - SLL: data_r <= {data_r[15-s:0], s zeros}
  - ROR: data_r <= {data_r[s-1:0], data_r[15:s]}
  - SRL: data_r <= {s zeros, data_r[15:s]}
  - cnt increments each cycle. After the cnt=3 stage is applied, go to DONE.
  - All four stages always execute; there is no early exit for zero amounts.
- DONE:
  - out_valid=1 and out_data=data_r.
  - On out_ready=1, go to IDLE.
  - Otherwise hold; data_r, amt_r and op_r are frozen.
- in_ready=0 in RUN and DONE. in_valid asserted there is ignored and not queued.
- out_data always drives data_r and is meaningful only while out_valid=1.
- out_ready outside DONE is ignored.
- Arithmetic rules:
  - Pure bit permutation plus zero fill. No sign extension and no flags.
  - Amount 0 returns the operand unchanged.
  - ROL by n equals ROR by (16-n) mod 16.

## Timing
- Reset values (one edge with rst=1): state=IDLE, cnt=0, data_r=0x0000, amt_r=0, op_r=0. Outputs: in_ready=1, out_valid=0, out_data=0x0000, busy=0.
- Reset has priority over every handshake. rst asserted in RUN or DONE aborts the operation with no output. The result is discarded even if out_ready=1 in the same cycle.
- Latency: a request accepted in cycle T (in_valid & in_ready high at the edge ending T) gives RUN in cycles T+1..T+4 and out_valid=1 from cycle T+5.
- Minimum occupancy is 6 cycles per operation:
  - Result taken in cycle T+5 gives IDLE in T+6.
  - The next request is accepted no earlier than T+6.
- Backpressure: out_valid stays 1 and out_data stays stable until the cycle out_ready=1. out_valid drops the following cycle.
- in_ready is a pure function of state (registered state, no combinational path from in_valid).
- out_valid is likewise a pure function of state.
- No combinational path from out_ready to any output.

## Test plan
- Reset, then ROL in_data=0x8001 amt=1 accepted in cycle 0:
  - out_valid first high in cycle 5 with out_data=0x0003.
  - in_ready=0 and busy=1 in cycles 1–5.
- Sweep all four ops on 0x1234 at amt 0, 4 and 8:
  - ROL: 0x1234, 0x2341, 0x3412.
  - SLL: 0x1234, 0x2340, 0x3400.
  - ROR: 0x1234, 0x4123, 0x3412.
  - SRL: 0x1234, 0x0123, 0x0012.
- Extremes:
  - SLL 0x00FF amt=12 gives 0xF000.
  - ROR 0x0001 amt=15 gives 0x0002.
  - SRL 0x8000 amt=15 gives 0x0001.
  - ROL 0xFFFF amt=15 gives 0xFFFF.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid rises.
  - out_data is stable and in_ready stays 0 throughout.
  - A second in_valid pulse during this window is not accepted.
  - When out_ready=1, IDLE follows next cycle and the second request is accepted only after that.
- Reset mid-operation: assert rst in the 2nd RUN cycle.
  - Next cycle shows IDLE, in_ready=1, out_valid=0, out_data=0x0000.
  - The aborted result never appears.
- Back-to-back: in_valid held high with out_ready held high.
  - Each request is accepted every 6 cycles.
  - Results come out in order and match the reference model.
